seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial test-pattern generator. It is the transmitting end for the team's JK-flip-flop serial sequence detectors. On a start request it captures an N-bit pattern and shifts it out MSB first on a single-bit stream `x`, one bit per clock. It can repeat the pattern a programmable number of times, with an optional idle gap between repeats, so a detector can be driven with isolated, back-to-back or overlapping occurrences of its target sequence.

Parameters:
PAT_W, 4, pattern width in bits (minimum 2).
GAP_CYCLES, 0, idle cycles inserted between repeats (0..15; 0 = continuous stream).
RC_W, 4, width of repeat_cnt.

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous, active-high reset.
start  input  1  transmission request; sampled only in IDLE.
pattern  input  PAT_W  bit pattern; captured on the accepting edge.
repeat_cnt  input  RC_W  extra repetitions; total sends = repeat_cnt+1; captured with pattern.
x  output  1  serial data out, registered.
valid  output  1  x carries a pattern bit this cycle, registered.
busy  output  1  high in SEND and GAP.
done  output  1  one-cycle completion pulse.
state  output  2  current FSM state: IDLE=00, SEND=01, GAP=10, DONE=11.

Behaviour:
- One clock (clk). Asynchronous active-high reset (rst). Single always-block FSM plus datapath registers; all outputs registered.
- Reset (asynchronous, immediate, also mid-transmission):
  - x=0, valid=0, busy=0, done=0, state=IDLE.
  - Shift register, bit counter, repeat counter, gap counter all 0.
- IDLE:
  - On an edge with start=1: capture pattern into a hold register and the shift register, reps_left<=repeat_cnt, bitcnt<=PAT_W-1.
  - On the same edge: x<=pattern[PAT_W-1], valid<=1, busy<=1, state<=SEND.
  - Result: bit k of the send (k=0 is MSB) is on x during the (k+1)th cycle after the accepting edge.
- SEND:
  - Each edge presents the next bit MSB-first; bitcnt decrements.
  - After the last bit (bitcnt==0):
    - If reps_left==0: state<=DONE, x<=0, valid<=0, busy<=0, done<=1.
    - Else: reps_left decrements and the shift register reloads from the hold register.
      - GAP_CYCLES==0: go straight to the next MSB with no bubble (continuous stream).
      - GAP_CYCLES>0: state<=GAP, x<=0, valid<=0.
- GAP:
  - Lasts exactly GAP_CYCLES cycles with x=0, valid=0, busy=1.
  - On the final gap edge: x<=MSB, valid<=1, state<=SEND.
- DONE:
  - Lasts exactly one cycle with done=1.
  - Next edge: done<=0, state<=IDLE.
  - start in DONE is ignored.
- start while busy (SEND/GAP/DONE) is ignored. pattern and repeat_cnt changes after capture have no effect.
- Counts:
  - Bits emitted = PAT_W*(repeat_cnt+1).
  - Total busy cycles = PAT_W*(repeat_cnt+1) + GAP_CYCLES*repeat_cnt.
  - Counters do not wrap: the repeat_cnt maximum (2^RC_W-1) yields 2^RC_W sends.
- start held high continuously: a new transmission is accepted on the first IDLE edge, i.e. 2 cycles after the done pulse begins.
- start high while rst is asserted is not recorded. The first accept is the first edge after rst deasserts with start=1.

Test Plan:
1. PAT_W=4, GAP=0, pattern=4'b1011, repeat_cnt=0, 1-cycle start -> x=1,0,1,1 with valid=1 for 4 cycles; then done=1 for 1 cycle with x=0, busy=0; then state=00.
2. Same but repeat_cnt=2 -> 12 contiguous valid bits 1011_1011_1011 with no valid gap; busy high 12 cycles; single done pulse.
3. GAP_CYCLES=2, pattern=4'b0110, repeat_cnt=1 -> 0110, two cycles valid=0/x=0 with busy=1, then 0110, then done; busy total 10 cycles.
4. Change pattern to 4'b0000 and pulse start during bit 2 of a 1011 send -> output stream unchanged (1011), no restart, one done pulse only.
5. Assert rst asynchronously mid-cycle during bit 2 -> x, valid, busy, done drop to 0 before the next edge and state=00. After release, start with pattern=4'b1100 sends 1,1,0,0 normally.
6. start held high constantly with pattern=4'b1001, repeat_cnt=0 -> sends 1001, done, one IDLE edge, then 1001 again; period 6 cycles (4 SEND + DONE + accepting IDLE).

Source files
------------

// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx -- serial test-pattern generator
//
// Captures a PAT_W-bit pattern on a start request and shifts it out MSB first
// on x, one bit per clock. The pattern is sent repeat_cnt+1 times. Between
// repeats the stream either continues with no bubble (GAP_CYCLES=0) or idles
// for GAP_CYCLES cycles with x=0 / valid=0.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   transmission request, honoured only in IDLE
//   pattern    in   PAT_W-bit pattern, captured on the accepting edge
//   repeat_cnt in   extra repetitions (total sends = repeat_cnt+1)
//   x          out  serial data, registered
//   valid      out  x carries a pattern bit this cycle, registered
//   busy       out  high in SEND and GAP
//   done       out  one-cycle completion pulse
//   state      out  FSM state: IDLE=00 SEND=01 GAP=10 DONE=11
// -----------------------------------------------------------------------------
module seq_pattern_tx #(
  parameter int PAT_W      = 4,
  parameter int GAP_CYCLES = 0,
  parameter int RC_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [RC_W-1:0]  repeat_cnt,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_SEND = 2'b01;
  localparam logic [1:0] S_GAP  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  localparam int BW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
  // Gap counter is loaded with GAP_CYCLES-1 so the GAP state lasts exactly
  // GAP_CYCLES cycles; clamped so GAP_CYCLES=0 still elaborates cleanly.
  localparam logic [3:0]    GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [1:0]       state_q,  state_d;
  logic [PAT_W-1:0] hold_q,   hold_d;
  logic [PAT_W-1:0] shift_q,  shift_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [RC_W-1:0]  reps_q,   reps_d;
  logic [3:0]       gapcnt_q, gapcnt_d;
  logic             x_q,      x_d;
  logic             valid_q,  valid_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  // The shift register always holds the bits still to be sent, MSB-aligned:
  // when a bit is driven onto x, the register shifts so its MSB is the next
  // bit. bitcnt counts bits remaining after the one currently on x.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    reps_d   = reps_q;
    gapcnt_d = gapcnt_q;
    x_d      = x_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = done_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          hold_d   = pattern;
          shift_d  = pattern << 1;
          reps_d   = repeat_cnt;
          bitcnt_d = BIT_LAST;
          x_d      = pattern[PAT_W-1];
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_SEND;
        end
      end

      S_SEND: begin
        if (bitcnt_q != '0) begin
          x_d      = shift_q[PAT_W-1];
          shift_d  = shift_q << 1;
          bitcnt_d = bitcnt_q - BW'(1);
        end else if (reps_q == '0) begin
          state_d = S_DONE;
          x_d     = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          reps_d = reps_q - RC_W'(1);
          if (GAP_CYCLES == 0) begin
            // Back-to-back: next MSB follows the last bit with no bubble.
            x_d      = hold_q[PAT_W-1];
            shift_d  = hold_q << 1;
            bitcnt_d = BIT_LAST;
          end else begin
            // Reload the full pattern; its MSB is presented on the last gap edge.
            state_d  = S_GAP;
            x_d      = 1'b0;
            valid_d  = 1'b0;
            shift_d  = hold_q;
            gapcnt_d = GAP_LAST;
          end
        end
      end

      S_GAP: begin
        if (gapcnt_q == '0) begin
          x_d      = shift_q[PAT_W-1];
          shift_d  = shift_q << 1;
          bitcnt_d = BIT_LAST;
          valid_d  = 1'b1;
          state_d  = S_SEND;
        end else begin
          gapcnt_d = gapcnt_q - 4'd1;
        end
      end

      default: begin  // S_DONE: one cycle, start ignored
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      reps_q   <= '0;
      gapcnt_q <= '0;
      x_q      <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      reps_q   <= reps_d;
      gapcnt_q <= gapcnt_d;
      x_q      <= x_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x     = x_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed-vector bench for seq_pattern_tx. Instance A runs with no gap,
// instance B with GAP_CYCLES=2. Each table row is one clock: inputs driven on
// the falling edge, outputs {x,valid,busy,done,state} sampled 1 after the rise.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [3:0] pat_a, pat_b, rc_a, rc_b;
  logic       x_a, valid_a, busy_a, done_a;
  logic       x_b, valid_b, busy_b, done_b;
  logic [1:0] st_a, st_b;

  always #5 clk = ~clk;

  seq_pattern_tx #(.PAT_W(4), .GAP_CYCLES(0), .RC_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pattern(pat_a), .repeat_cnt(rc_a),
    .x(x_a), .valid(valid_a), .busy(busy_a), .done(done_a), .state(st_a));

  seq_pattern_tx #(.PAT_W(4), .GAP_CYCLES(2), .RC_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pattern(pat_b), .repeat_cnt(rc_b),
    .x(x_b), .valid(valid_b), .busy(busy_b), .done(done_b), .state(st_b));

  typedef struct {
    string      name;
    bit         sel;     // 0 = dut_a, 1 = dut_b
    bit         start;
    logic [3:0] pat;
    logic [3:0] rc;
    logic [5:0] exp;     // {x,valid,busy,done,state}
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(string n, bit sel, bit s, logic [3:0] p, logic [3:0] r,
                              bit ex, bit ev, bit eb, bit ed, logic [1:0] est);
    vec_t v;
    v.name = n; v.sel = sel; v.start = s; v.pat = p; v.rc = r;
    v.exp = {ex, ev, eb, ed, est};
    return v;
  endfunction

  task automatic check(string name, logic [5:0] act, logic [5:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got {x,v,b,d,st}=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs_a();
    return {x_a, valid_a, busy_a, done_a, st_a};
  endfunction

  function automatic logic [5:0] outs_b();
    return {x_b, valid_b, busy_b, done_b, st_b};
  endfunction

  initial begin
    logic [3:0] p;
    int cnt_v, cnt_b, bit_err, k;
    bit got_done;
    logic [5:0] rexp[6];

    rst = 1'b1; start_a = 0; start_b = 0;
    pat_a = '0; pat_b = '0; rc_a = '0; rc_b = '0;

    // ---------------- table ----------------
    // 1: single send of 1011
    tbl.push_back(mk("t1_b0",   0, 1, 4'b1011, 0, 1,1,1,0, 2'b01));
    tbl.push_back(mk("t1_b1",   0, 0, 4'b1011, 0, 0,1,1,0, 2'b01));
    tbl.push_back(mk("t1_b2",   0, 0, 4'b1011, 0, 1,1,1,0, 2'b01));
    tbl.push_back(mk("t1_b3",   0, 0, 4'b1011, 0, 1,1,1,0, 2'b01));
    tbl.push_back(mk("t1_done", 0, 0, 4'b1011, 0, 0,0,0,1, 2'b11));
    tbl.push_back(mk("t1_idle", 0, 0, 4'b1011, 0, 0,0,0,0, 2'b00));
    // 2: three contiguous sends of 1011
    p = 4'b1011;
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk($sformatf("t2_bit%0d", i), 0, (i == 0), p, 2,
                       p[3 - (i % 4)], 1, 1, 0, 2'b01));
    tbl.push_back(mk("t2_done", 0, 0, p, 2, 0,0,0,1, 2'b11));
    tbl.push_back(mk("t2_idle", 0, 0, p, 2, 0,0,0,0, 2'b00));
    // 4: pattern change and start pulse mid-send; start in DONE also ignored
    tbl.push_back(mk("t4_b0",   0, 1, 4'b1011, 0, 1,1,1,0, 2'b01));
    tbl.push_back(mk("t4_b1",   0, 0, 4'b0000, 0, 0,1,1,0, 2'b01));
    tbl.push_back(mk("t4_b2",   0, 1, 4'b0000, 0, 1,1,1,0, 2'b01));
    tbl.push_back(mk("t4_b3",   0, 0, 4'b0000, 0, 1,1,1,0, 2'b01));
    tbl.push_back(mk("t4_done", 0, 0, 4'b0000, 0, 0,0,0,1, 2'b11));
    tbl.push_back(mk("t4_idle", 0, 1, 4'b0000, 0, 0,0,0,0, 2'b00));
    tbl.push_back(mk("t4_stay", 0, 0, 4'b0000, 0, 0,0,0,0, 2'b00));
    // 6: start held high, 6-cycle period
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk("t6_b0",   0, 1, 4'b1001, 0, 1,1,1,0, 2'b01));
      tbl.push_back(mk("t6_b1",   0, 1, 4'b1001, 0, 0,1,1,0, 2'b01));
      tbl.push_back(mk("t6_b2",   0, 1, 4'b1001, 0, 0,1,1,0, 2'b01));
      tbl.push_back(mk("t6_b3",   0, 1, 4'b1001, 0, 1,1,1,0, 2'b01));
      tbl.push_back(mk("t6_done", 0, 1, 4'b1001, 0, 0,0,0,1, 2'b11));
      tbl.push_back(mk("t6_idle", 0, 1, 4'b1001, 0, 0,0,0,0, 2'b00));
    end
    tbl.push_back(mk("t6_stop", 0, 0, 4'b1001, 0, 0,0,0,0, 2'b00));
    // 3: gap of 2 between two sends of 0110 (dut_b)
    tbl.push_back(mk("t3_a0",   1, 1, 4'b0110, 1, 0,1,1,0, 2'b01));
    tbl.push_back(mk("t3_a1",   1, 0, 4'b0110, 1, 1,1,1,0, 2'b01));
    tbl.push_back(mk("t3_a2",   1, 0, 4'b0110, 1, 1,1,1,0, 2'b01));
    tbl.push_back(mk("t3_a3",   1, 0, 4'b0110, 1, 0,1,1,0, 2'b01));
    tbl.push_back(mk("t3_gap0", 1, 0, 4'b0110, 1, 0,0,1,0, 2'b10));
    tbl.push_back(mk("t3_gap1", 1, 0, 4'b0110, 1, 0,0,1,0, 2'b10));
    tbl.push_back(mk("t3_b0",   1, 0, 4'b0110, 1, 0,1,1,0, 2'b01));
    tbl.push_back(mk("t3_b1",   1, 0, 4'b0110, 1, 1,1,1,0, 2'b01));
    tbl.push_back(mk("t3_b2",   1, 0, 4'b0110, 1, 1,1,1,0, 2'b01));
    tbl.push_back(mk("t3_b3",   1, 0, 4'b0110, 1, 0,1,1,0, 2'b01));
    tbl.push_back(mk("t3_done", 1, 0, 4'b0110, 1, 0,0,0,1, 2'b11));
    tbl.push_back(mk("t3_idle", 1, 0, 4'b0110, 1, 0,0,0,0, 2'b00));

    // ---------------- reset state ----------------
    #1;
    check("rst_a", outs_a(), 6'b0);
    check("rst_b", outs_b(), 6'b0);
    @(negedge clk); rst = 1'b0;

    // ---------------- table loop ----------------
    foreach (tbl[i]) begin
      @(negedge clk);
      if (tbl[i].sel) begin
        start_a = 0; start_b = tbl[i].start; pat_b = tbl[i].pat; rc_b = tbl[i].rc;
      end else begin
        start_b = 0; start_a = tbl[i].start; pat_a = tbl[i].pat; rc_a = tbl[i].rc;
      end
      @(posedge clk); #1;
      check(tbl[i].name, tbl[i].sel ? outs_b() : outs_a(), tbl[i].exp);
    end
    @(negedge clk); start_b = 0;

    // ---------------- maximum repeat_cnt: 16 sends, no wrap ----------------
    p = 4'b1010;
    start_a = 1; pat_a = p; rc_a = 4'hF;
    cnt_v = 0; cnt_b = 0; bit_err = 0; k = 0; got_done = 0;
    @(posedge clk); #1;
    for (int n = 0; n < 200 && !got_done; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (n == 0) start_a = 0;
      if (valid_a) begin
        if (x_a !== p[3 - (k % 4)]) bit_err++;
        k++; cnt_v++;
      end
      if (busy_a) cnt_b++;
      if (done_a) got_done = 1;
    end
    check("max_done_seen", {5'b0, got_done}, 6'd1);
    check("max_valid_cnt", 6'(cnt_v >> 1), 6'd32);
    check("max_busy_cnt",  6'(cnt_b >> 1), 6'd32);
    check("max_bits_ok",   6'(bit_err), 6'd0);
    @(posedge clk); #1;
    check("max_idle", outs_a(), 6'b000000);

    // ---------------- async reset mid-send, then restart ----------------
    @(negedge clk); start_a = 1; pat_a = 4'b1011; rc_a = 0;
    @(posedge clk); #1; check("r_b0", outs_a(), 6'b111001);
    @(negedge clk); start_a = 0;
    @(posedge clk); #1; check("r_b1", outs_a(), 6'b011001);
    @(posedge clk); #1; check("r_b2", outs_a(), 6'b111001);
    #2 rst = 1'b1;
    #1 check("r_async", outs_a(), 6'b000000);
    @(negedge clk); start_a = 1; pat_a = 4'b1100;
    @(posedge clk); #1; check("r_held", outs_a(), 6'b000000);
    @(negedge clk); rst = 1'b0;
    rexp[0] = 6'b111001; rexp[1] = 6'b111001; rexp[2] = 6'b011001;
    rexp[3] = 6'b011001; rexp[4] = 6'b000111; rexp[5] = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("r_after%0d", i), outs_a(), rexp[i]);
      @(negedge clk); start_a = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
